button_group_arbiter: RTL
=========================

Name: button_group_arbiter

Overview:
- Sequences and shares the mouse-click path between N on-screen buttons, e.g. the card tiles of the memory board.
- Collects the per-button `button_pressed` pulses and grants exactly one press per click.
- Drives each button's `enable` so that no second press registers until the lockout has expired and the left mouse button is released.
- Sits between the button instances and the game FSM; the FSM consumes `press_valid`/`press_index`.

Parameters:
- N_BUTTONS, 4, number of buttons arbitrated (2..16).
- IDX_WIDTH, 2, width of `press_index`; must satisfy 2^IDX_WIDTH >= N_BUTTONS.
- LOCKOUT_CYCLES, 650000, post-grant lockout length in clk cycles (10 ms at 65 MHz); must be >= 1.
- CNT_WIDTH, 20, lockout counter width; must hold LOCKOUT_CYCLES-1.

Ports:
- clk  in  1  pixel/system clock.
- rst  in  1  synchronous active-high reset.
- group_enable  in  1  game FSM allows presses on this button group.
- mouse_left  in  1  left mouse button level.
- button_pressed  in  N_BUTTONS  press pulses, bit i from button i.
- button_enable  out  N_BUTTONS  enable to each button (press checker and display).
- press_valid  out  1  one-cycle grant pulse.
- press_index  out  IDX_WIDTH  index of the granted button; holds its value between grants.
- busy  out  1  high when the state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, button_enable=0, press_valid=0, press_index=0, busy=0, counter=0.
- States: IDLE, LOCK, RELEASE.
- IDLE, group_enable=1, button_pressed==0:
  - button_enable <= all ones.
- IDLE, group_enable=1, button_pressed!=0 sampled at cycle t:
  - at t+1: press_valid=1 for exactly one cycle, press_index=granted index, button_enable=0, busy=1.
  - state -> LOCK; counter loaded with LOCKOUT_CYCLES-1.
- Grant selection: the lowest set bit of button_pressed (fixed priority). Other simultaneous bits are dropped, not queued.
- LOCK:
  - button_enable=0.
  - Counter decrements once per cycle.
  - When counter==0: state -> RELEASE. LOCK therefore lasts exactly LOCKOUT_CYCLES cycles.
- RELEASE:
  - button_enable=0.
  - When mouse_left==0: state -> IDLE, and button_enable returns to all ones on the following cycle.
  - If mouse_left is already 0 on entry, the block spends one cycle in RELEASE.
- group_enable=0 in any state:
  - next cycle: state=IDLE, button_enable=0, counter=0, press_valid=0.
  - Presses are ignored while group_enable=0.
  - press_index is not cleared.
- group_enable re-asserted: button_enable goes to all ones one cycle later, provided no press is sampled in that cycle.
- Presses arriving in LOCK or RELEASE are ignored; there is no latching.
- Bits at or above N_BUTTONS do not exist. press_index never exceeds N_BUTTONS-1.
- rst asserted mid-LOCK: all values return to reset values on the next edge; no press_valid is emitted.

Optional Feature:
- Macro: BUTTON_ARB_ROUND_ROBIN_EN.
- Defined:
  - Priority rotates. A pointer register (reset 0) names the highest-priority index.
  - The grant is the first set bit searched from the pointer upward, wrapping modulo N_BUTTONS.
  - On each grant, pointer <= granted index + 1, wrapping N_BUTTONS-1 -> 0.
  - group_enable=0 does not reset the pointer; rst does.
- Not defined: fixed lowest-index priority; no pointer register exists.

Test Plan:
- Reset, then group_enable=1 with no press -> button_enable=4'b1111 one cycle later; press_valid=0; busy=0.
- Single-cycle button_pressed=4'b0100 at cycle t -> at t+1: press_valid=1, press_index=2, button_enable=0, busy=1; press_valid=0 at t+2.
- Check timing with LOCKOUT_CYCLES=8 and mouse_left held high -> exactly 8 LOCK cycles, then RELEASE; a press pulse during LOCK produces no grant.
- Release mouse_left at cycle r -> state IDLE at r+1, button_enable=1111 at r+2, busy=0 at r+1.
- Simultaneous button_pressed=4'b1010 -> press_index=1 without the macro. With BUTTON_ARB_ROUND_ROBIN_EN, two successive 1010 grants yield 1 then 3.
- Drive group_enable=0 mid-LOCK -> next cycle state=IDLE, button_enable=0, busy=0. A press with group_enable=0 gives no grant; press_index retains its last value.

Source files
------------

// File: rtl/button_group_arbiter_if.sv
// Button-group arbiter bus: press inputs from the buttons/FSM, grant outputs to the FSM.
// master = arbiter side, slave = game FSM / button side.
interface button_group_arbiter_if #(
    parameter int N_BUTTONS = 4,
    parameter int IDX_WIDTH = 2
);
    logic                 group_enable;
    logic                 mouse_left;
    logic [N_BUTTONS-1:0] button_pressed;
    logic [N_BUTTONS-1:0] button_enable;
    logic                 press_valid;
    logic [IDX_WIDTH-1:0] press_index;
    logic                 busy;

    modport master (
        input  group_enable,
        input  mouse_left,
        input  button_pressed,
        output button_enable,
        output press_valid,
        output press_index,
        output busy
    );

    modport slave (
        output group_enable,
        output mouse_left,
        output button_pressed,
        input  button_enable,
        input  press_valid,
        input  press_index,
        input  busy
    );
endinterface

// File: rtl/button_group_arbiter.sv
// Grants one button press per click, then locks the group until lockout expires and the mouse is released.
// Optional macro BUTTON_ARB_ROUND_ROBIN_EN selects rotating priority instead of lowest-index priority.
module button_group_arbiter #(
    parameter int N_BUTTONS      = 4,
    parameter int IDX_WIDTH      = 2,
    parameter int LOCKOUT_CYCLES = 650000,
    parameter int CNT_WIDTH      = 20
) (
    input logic                    clk,
    input logic                    rst,
    button_group_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOCK,
        RELEASE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] lockCnt_q, lockCnt_d;
    logic [N_BUTTONS-1:0] buttonEnable_q, buttonEnable_d;
    logic                 pressValid_q, pressValid_d;
    logic [IDX_WIDTH-1:0] pressIndex_q, pressIndex_d;
    logic                 busy_q, busy_d;

    logic                 grantHit;
    logic [IDX_WIDTH-1:0] grantIdx;

`ifdef BUTTON_ARB_ROUND_ROBIN_EN
    logic [IDX_WIDTH-1:0] rrPtr_q, rrPtr_d;
    int                   rrDist;
    int                   rrBest;

    // Winner is the set bit with the smallest wrapped distance above the pointer.
    always_comb begin
        grantHit = |bus.button_pressed;
        grantIdx = '0;
        rrDist   = 0;
        rrBest   = N_BUTTONS;
        for (int i = 0; i < N_BUTTONS; i++) begin
            if (bus.button_pressed[i]) begin
                rrDist = (i + N_BUTTONS - int'(rrPtr_q)) % N_BUTTONS;
                if (rrDist < rrBest) begin
                    rrBest   = rrDist;
                    grantIdx = IDX_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        rrPtr_d = rrPtr_q;
        if (state_q == IDLE && bus.group_enable && grantHit) begin
            rrPtr_d = (grantIdx == IDX_WIDTH'(N_BUTTONS - 1)) ? '0 : grantIdx + IDX_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rrPtr_q <= '0;
        else     rrPtr_q <= rrPtr_d;
    end
`else
    always_comb begin
        grantHit = |bus.button_pressed;
        grantIdx = '0;
        for (int i = N_BUTTONS - 1; i >= 0; i--) begin
            if (bus.button_pressed[i]) grantIdx = IDX_WIDTH'(i);
        end
    end
`endif

    always_comb begin
        state_d        = state_q;
        lockCnt_d      = lockCnt_q;
        buttonEnable_d = buttonEnable_q;
        pressValid_d   = 1'b0;
        pressIndex_d   = pressIndex_q;

        // Dropping group_enable aborts any click in progress but keeps the last index.
        if (!bus.group_enable) begin
            state_d        = IDLE;
            lockCnt_d      = '0;
            buttonEnable_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grantHit) begin
                        state_d        = LOCK;
                        lockCnt_d      = CNT_WIDTH'(LOCKOUT_CYCLES - 1);
                        buttonEnable_d = '0;
                        pressValid_d   = 1'b1;
                        pressIndex_d   = grantIdx;
                    end else begin
                        buttonEnable_d = '1;
                    end
                end
                LOCK: begin
                    buttonEnable_d = '0;
                    if (lockCnt_q == '0) state_d = RELEASE;
                    else                 lockCnt_d = lockCnt_q - CNT_WIDTH'(1);
                end
                RELEASE: begin
                    buttonEnable_d = '0;
                    if (!bus.mouse_left) state_d = IDLE;
                end
                default: begin
                    state_d        = IDLE;
                    buttonEnable_d = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            lockCnt_q      <= '0;
            buttonEnable_q <= '0;
            pressValid_q   <= 1'b0;
            pressIndex_q   <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            lockCnt_q      <= lockCnt_d;
            buttonEnable_q <= buttonEnable_d;
            pressValid_q   <= pressValid_d;
            pressIndex_q   <= pressIndex_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.button_enable = buttonEnable_q;
    assign bus.press_valid   = pressValid_q;
    assign bus.press_index   = pressIndex_q;
    assign bus.busy          = busy_q;

endmodule
